// File: rtl/toggle_hs_responder.sv
// toggle_hs_responder: responder side of a 2-phase req/ack handshake.
// Captures each request word into a FWFT FIFO drained by valid/ready.
module toggle_hs_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_tgl,
  input  logic [DATA_W-1:0]                    req_data,
  output logic                                 ack_tgl,
  output logic                                 req_pulse,
  output logic                                 out_valid,
  output logic [DATA_W-1:0]                    out_data,
  input  logic                                 out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   chain;
  logic                   req_s;
  logic                   req_nxt;
  logic                   pending;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];

  // chain[0] is the raw input, chain[SYNC_STAGES] the synchronized level
  assign chain   = {sync_q, req_tgl};
  assign req_s   = chain[SYNC_STAGES];
  assign req_nxt = chain[SYNC_STAGES-1];

  assign pending   = req_s != ack_tgl;
  assign full      = fifo_count == CW'(FIFO_DEPTH);
  assign push      = pending && !full;
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Synchronizer, handshake state and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      ack_tgl   <= 1'b0;
      req_pulse <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      sync_q    <= chain[SYNC_STAGES-1:0];
      ack_tgl   <= ack_tgl ^ push;
      req_pulse <= push;
      if (pending && (req_nxt != req_s))
        proto_err <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; full/empty come from the count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (pop && !push)
        fifo_count <= fifo_count - CW'(1);
    end
  end

  // Storage array; contents are irrelevant until written
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= req_data;
  end

endmodule

// File: tb/tb_toggle_hs_responder.sv
// tb_toggle_hs_responder: directed and random checks of the
// toggle handshake responder against a queue-based reference model.
module tb_toggle_hs_responder;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int FD = 4;
  localparam int CW = $clog2(FD+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_tgl = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          out_ready = 1'b0;
  logic          ack_tgl;
  logic          req_pulse;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] fifo_count;
  logic          proto_err;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit            hist[$];
  logic [DW-1:0] mq[$];
  bit            m_ack;
  bit            m_pulse;
  bit            m_perr;

  // words the initiator still has to send
  logic [DW-1:0] txq[$];

  toggle_hs_responder #(
    .DATA_W(DW),
    .SYNC_STAGES(SS),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_tgl(req_tgl),
    .req_data(req_data),
    .ack_tgl(ack_tgl),
    .req_pulse(req_pulse),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .fifo_count(fifo_count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge of the handshake as the rules describe it:
  // req_s is req_tgl delayed SS edges; a word is accepted when
  // it is pending and the queue was not full before the edge.
  task automatic model_edge();
    bit old_s, new_s, pend, was_full, do_pop;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      mq.delete();
      m_ack = 0;
      m_pulse = 0;
      m_perr = 0;
    end else begin
      old_s = hist[0];
      pend = old_s != m_ack;
      was_full = mq.size() == FD;
      do_pop = mq.size() > 0 && out_ready;
      hist.push_back(req_tgl);
      void'(hist.pop_front());
      new_s = hist[0];
      if (pend && new_s != old_s) m_perr = 1;
      if (do_pop) void'(mq.pop_front());
      m_pulse = pend && !was_full;
      if (m_pulse) begin
        mq.push_back(req_data);
        m_ack = ~m_ack;
      end
    end
  endtask

  task automatic compare_all();
    check("ack", 32'(ack_tgl), 32'(m_ack));
    check("pulse", 32'(req_pulse), 32'(m_pulse));
    check("perr", 32'(proto_err), 32'(m_perr));
    check("count", 32'(fifo_count), 32'(mq.size()));
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() > 0)
      check("data", 32'(out_data), 32'(mq[0]));
  endtask

  // Initiator: new toggle only once the previous one was acknowledged
  task automatic drive();
    if (!rst && txq.size() > 0 && req_tgl == ack_tgl) begin
      req_data = txq.pop_front();
      req_tgl = ~req_tgl;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    drive();
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((txq.size() > 0 || req_tgl != ack_tgl) && n < budget) begin
      step();
      n++;
    end
    check("idle_wait", 32'(n < budget), 1);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_count", 32'(fifo_count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ack", 32'(ack_tgl), 0);
    check("rst_perr", 32'(proto_err), 0);

    // single transfer
    req_data = 8'hA5;
    req_tgl = 1'b1;
    repeat (SS) step();
    check("st_ack_early", 32'(ack_tgl), 0);
    step();
    check("st_ack", 32'(ack_tgl), 1);
    check("st_pulse", 32'(req_pulse), 1);
    check("st_data", 32'(out_data), 'hA5);
    check("st_count", 32'(fifo_count), 1);
    step();
    check("st_pulse_off", 32'(req_pulse), 0);
    out_ready = 1'b1;
    step();
    check("st_drain", 32'(out_valid), 0);
    out_ready = 1'b0;

    // fill and stall
    for (int i = 1; i <= 5; i++) txq.push_back(DW'(i));
    repeat (40) step();
    check("fill_count", 32'(fifo_count), 4);
    check("fill_wait", 32'(req_tgl != ack_tgl), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall_pop", 32'(fifo_count), 3);
    check("stall_head", 32'(out_data), 2);
    step();
    check("stall_push", 32'(fifo_count), 4);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("drain", 32'(out_data), 32'(k));
      step();
    end
    check("drain_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // simultaneous push and pop at count 2
    txq.push_back(8'h10);
    txq.push_back(8'h11);
    wait_idle(40);
    req_data = 8'h12;
    req_tgl = ~req_tgl;
    repeat (SS) step();
    out_ready = 1'b1;
    step();
    check("sim_count", 32'(fifo_count), 2);
    check("sim_head", 32'(out_data), 'h11);
    repeat (4) step();
    out_ready = 1'b0;

    // pointer wrap
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) txq.push_back(DW'(8'h20 + i));
    wait_idle(200);
    repeat (3) step();
    out_ready = 1'b0;
    check("wrap_empty", 32'(out_valid), 0);

    // protocol error while full
    for (int i = 0; i < 4; i++) txq.push_back(DW'(8'h30 + i));
    wait_idle(80);
    check("pe_full", 32'(fifo_count), 4);
    req_data = 8'h34;
    req_tgl = ~req_tgl;
    repeat (SS + 2) step();
    check("pe_none_yet", 32'(proto_err), 0);
    req_tgl = ~req_tgl;
    repeat (SS + 2) step();
    check("pe_set", 32'(proto_err), 1);
    check("pe_count", 32'(fifo_count), 4);
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    check("pe_sticky", 32'(proto_err), 1);
    check("pe_nocap", 32'(out_valid), 0);

    // reset mid-operation
    for (int i = 0; i < 3; i++) txq.push_back(DW'(8'h40 + i));
    wait_idle(40);
    req_data = 8'h43;
    req_tgl = ~req_tgl;
    step();
    rst = 1'b1;
    req_tgl = 1'b0;
    step();
    rst = 1'b0;
    check("mr_count", 32'(fifo_count), 0);
    check("mr_valid", 32'(out_valid), 0);
    check("mr_ack", 32'(ack_tgl), 0);
    check("mr_perr", 32'(proto_err), 0);
    repeat (6) begin
      step();
      check("mr_nospur", 32'(req_pulse), 0);
    end

    // random traffic with occasional resets
    repeat (3000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (txq.size() == 0 && $urandom_range(0, 3) == 0)
        txq.push_back(DW'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        req_tgl = 1'b0;
        txq.delete();
      end else begin
        rst = 1'b0;
      end
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_hs_responder.md
Name: toggle_hs_responder

Overview:
- Responder end of a 2-phase (toggle) request/acknowledge handshake.
- The initiator signals each new word by toggling `req_tgl` from a T-flip-flop-style toggle register, and holds `req_data` stable until it sees `ack_tgl` toggle back.
- This block detects request toggles, captures the data into a small first-word-fall-through FIFO and returns an acknowledge toggle.
- Downstream logic drains the FIFO through a valid/ready interface.

Parameters:
- DATA_W, 8, width of `req_data` and `out_data`.
- SYNC_STAGES, 2, register stages on `req_tgl` before detection; legal range 1..3.
- FIFO_DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset; sampled on posedge `clk`.
- req_tgl  in  1  request toggle line; every level change is one request.
- req_data  in  DATA_W  request payload; stable from the `req_tgl` change until the matching `ack_tgl` change.
- ack_tgl  out  1  acknowledge toggle; one level change per accepted request.
- req_pulse  out  1  one-cycle pulse on each accepted request.
- out_valid  out  1  FIFO non-empty.
- out_data  out  DATA_W  FIFO head word (fall-through).
- out_ready  in  1  downstream accepts head when `out_valid` is high.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- proto_err  out  1  sticky: initiator toggled again before being acknowledged.

Behaviour:
- Reset, on a posedge `clk` with `rst`=1, clears everything to 0:
  - sync chain, `ack_tgl`, `req_pulse`, `proto_err`;
  - read/write pointers, `fifo_count` (so `out_valid`=0).
  - `out_data` is don't-care while `out_valid`=0.
  - Reset takes priority over every other event, including an in-progress push or pop.
- Sync chain: `req_tgl` passes through SYNC_STAGES flops; `req_s` is the last stage.
- pending = (`req_s` != `ack_tgl`).
- Accept condition: pending && (`fifo_count` < FIFO_DEPTH). On that edge:
  - `req_data` is written at the write pointer;
  - `ack_tgl` inverts;
  - `req_pulse`=1 for exactly that following cycle.
- Latency: if `req_tgl` changes before edge k with FIFO not full, the push and `ack_tgl` toggle occur at edge k+SYNC_STAGES; `req_pulse` is high during the cycle after that edge.
- Full: while pending with `fifo_count`=FIFO_DEPTH, the request waits.
  - No capture, no ack, `req_data` must still be held.
  - Accept occurs on the first edge where the count is below FIFO_DEPTH at the edge.
  - A pop in the same cycle does not enable a push; the push happens the next cycle.
- Pop: `out_valid` && `out_ready` advances the read pointer at the edge.
  - `out_ready` with `out_valid`=0 has no effect.
- Simultaneous push and pop (count between 1 and FIFO_DEPTH-1): count unchanged, both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; full/empty are derived from `fifo_count`.
- `fifo_count` range is 0..FIFO_DEPTH; it never over- or underflows.
- Protocol error: if `req_s` changes on an edge while pending was already 1 before that edge, set `proto_err`=1.
  - `proto_err` stays set until `rst`.
  - The data path is unaffected: pending then evaluates to 0, and that request pair is lost.
- Post-reset: if `req_tgl`=1 after reset, it is treated as a request once it propagates through the sync chain. The initiator's toggle register must be reset in the same cycle.

Test Plan:
- Single transfer: SYNC_STAGES=2; reset, then toggle `req_tgl` 0->1 with `req_data`=8'hA5 before edge 5 → `ack_tgl` 0->1 at edge 7, `req_pulse` high for that cycle, `out_valid`=1, `out_data`=8'hA5, `fifo_count`=1; with `out_ready`=1 → `out_valid`=0 next cycle.
- Fill and stall: `out_ready`=0; send 5 requests 8'h01..8'h05, each toggling after the previous ack → first 4 acked, `fifo_count`=4, 5th unacked; raise `out_ready` for one cycle → head 8'h01 pops, 5th acked the following edge, then drain yields 02,03,04,05 in order.
- Simultaneous push/pop: `fifo_count`=2, `out_ready`=1, request arrives → count stays 2 for that edge, data order preserved; pointer wrap verified by pushing 10 words through a 4-entry FIFO.
- Protocol error: toggle `req_tgl` twice with no ack in between while the FIFO is full → `proto_err`=1 and stays 1; no capture occurs, `ack_tgl` unchanged.
- Reset mid-operation: 3 words queued and a request pending; assert `rst` for 1 cycle → `fifo_count`=0, `out_valid`=0, `ack_tgl`=0, `proto_err`=0; with `req_tgl` also reset to 0, no spurious `req_pulse` follows.
